// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned ENTRY_W      = 2 * XLEN;
    localparam int unsigned FIFO_DEPTH_C = 2;
    localparam int unsigned CNT_W        = 2;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT      = 3'd2,
        ST_DROP_REQ  = 3'd3,
        ST_DROP_WAIT = 3'd4
    } fetch_state_e;

    // Sequential fetch address; wraps naturally modulo 2^32.
    function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

    // Force a target onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry shift-style instruction buffer; slot0 is always the head so the
// head word comes straight out of a register.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [ENTRY_W-1:0] head_data,
    output logic               head_valid,
    output logic [CNT_W-1:0]   count
);

    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(FIFO_DEPTH_C);

    logic [ENTRY_W-1:0] slot0_r;
    logic [ENTRY_W-1:0] slot1_r;
    logic [CNT_W-1:0]   count_r;
    logic               push_ok_s;
    logic               pop_ok_s;

    // Qualify push/pop against occupancy so misuse cannot corrupt the buffer.
    always_comb begin
        pop_ok_s  = pop && (count_r != 2'd0);
        push_ok_s = push && ((count_r != FULL_C) || pop_ok_s);
    end

    // Storage and occupancy update; flush and reset empty the buffer.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            slot0_r <= '0;
            slot1_r <= '0;
            count_r <= '0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        slot0_r <= push_data;
                    end else begin
                        slot1_r <= push_data;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    slot0_r <= slot1_r;
                    slot1_r <= '0;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        slot0_r <= push_data;
                    end else begin
                        slot0_r <= slot1_r;
                        slot1_r <= push_data;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign head_data  = slot0_r;
    assign head_valid = (count_r != 2'd0);
    assign count      = count_r;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, redirect
// handling with response dropping, and a two-entry buffer toward decode.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     FIFO_DEPTH = FIFO_DEPTH_C
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    fetch_state_e       state_r;
    logic [XLEN-1:0]    pc_r;
    logic               mem_req_r;
    logic [XLEN-1:0]    mem_addr_r;

    logic [XLEN-1:0]    redirect_tgt_s;
    logic [XLEN-1:0]    pc_plus4_s;
    logic [XLEN-1:0]    drop_resume_pc_s;
    logic               push_s;
    logic               pop_s;
    logic               flush_s;
    logic [CNT_W-1:0]   count_after_push_s;
    logic [CNT_W-1:0]   fifo_count_s;
    logic [ENTRY_W-1:0] head_data_s;
    logic               head_valid_s;

    // Buffer control and next-address helpers; a redirect always flushes and
    // suppresses any same-cycle push.
    always_comb begin
        redirect_tgt_s     = word_align(redirect_pc_i);
        pc_plus4_s         = pc_incr(pc_r);
        drop_resume_pc_s   = redirect_valid_i ? redirect_tgt_s : pc_r;
        pop_s              = head_valid_s && inst_ready_i;
        flush_s            = redirect_valid_i;
        push_s             = (state_r == ST_WAIT) && mem_rvalid_i && !redirect_valid_i;
        count_after_push_s = fifo_count_s + 2'd1 - {1'b0, pop_s};
    end

    // Fetch FSM with registered request/address outputs; the address is held
    // through DROP_REQ while pc already tracks the redirect target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            mem_req_r  <= 1'b0;
            mem_addr_r <= RESET_PC;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (redirect_valid_i) begin
                        state_r    <= ST_REQ;
                        pc_r       <= redirect_tgt_s;
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= redirect_tgt_s;
                    end else if (fifo_count_s < DEPTH_C) begin
                        state_r    <= ST_REQ;
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= pc_r;
                    end else begin
                        state_r   <= ST_IDLE;
                        mem_req_r <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (redirect_valid_i) begin
                        pc_r <= redirect_tgt_s;
                        if (mem_gnt_i) begin
                            state_r   <= ST_DROP_WAIT;
                            mem_req_r <= 1'b0;
                        end else begin
                            state_r   <= ST_DROP_REQ;
                            mem_req_r <= 1'b1;
                        end
                    end else if (mem_gnt_i) begin
                        state_r   <= ST_WAIT;
                        mem_req_r <= 1'b0;
                    end else begin
                        state_r   <= ST_REQ;
                        mem_req_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (redirect_valid_i) begin
                        pc_r <= redirect_tgt_s;
                        if (mem_rvalid_i) begin
                            state_r    <= ST_REQ;
                            mem_req_r  <= 1'b1;
                            mem_addr_r <= redirect_tgt_s;
                        end else begin
                            state_r   <= ST_DROP_WAIT;
                            mem_req_r <= 1'b0;
                        end
                    end else if (mem_rvalid_i) begin
                        pc_r <= pc_plus4_s;
                        if (count_after_push_s < DEPTH_C) begin
                            state_r    <= ST_REQ;
                            mem_req_r  <= 1'b1;
                            mem_addr_r <= pc_plus4_s;
                        end else begin
                            state_r   <= ST_IDLE;
                            mem_req_r <= 1'b0;
                        end
                    end else begin
                        state_r   <= ST_WAIT;
                        mem_req_r <= 1'b0;
                    end
                end
                ST_DROP_REQ: begin
                    if (redirect_valid_i) begin
                        pc_r <= redirect_tgt_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                    if (mem_gnt_i) begin
                        state_r   <= ST_DROP_WAIT;
                        mem_req_r <= 1'b0;
                    end else begin
                        state_r   <= ST_DROP_REQ;
                        mem_req_r <= 1'b1;
                    end
                end
                ST_DROP_WAIT: begin
                    pc_r <= drop_resume_pc_s;
                    if (mem_rvalid_i) begin
                        state_r    <= ST_REQ;
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= drop_resume_pc_s;
                    end else begin
                        state_r   <= ST_DROP_WAIT;
                        mem_req_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_data  ({mem_rdata_i, mem_addr_r}),
        .pop        (pop_s),
        .flush      (flush_s),
        .head_data  (head_data_s),
        .head_valid (head_valid_s),
        .count      (fifo_count_s)
    );

    assign mem_req_o    = mem_req_r;
    assign mem_addr_o   = mem_addr_r;
    assign inst_valid_o = head_valid_s;
    assign inst_o       = head_data_s[ENTRY_W-1:XLEN];
    assign inst_pc_o    = head_data_s[XLEN-1:0];

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run
// checked against a program-order model of the delivered instruction stream.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_gnt_i        (mem_gnt_i),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rdata_i      (mem_rdata_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    // Contents of instruction memory at a given address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;
        mem_gnt_i        = 1'b0;
        mem_rvalid_i     = 1'b0;
        mem_rdata_i      = 32'h0;
        inst_ready_i     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        inst_ready_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 32'h500;
        tick(); tick(); tick();
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b exp=0", mem_req_o); end
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", inst_valid_o); end
        checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", inst_o); end
        checks++; if (inst_pc_o !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got=%h exp=0", inst_pc_o); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_addr_o); end
        rst = 1'b0;
        idle_inputs();
        tick();
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
            errors++; $display("FAIL first_req got req=%0b addr=%h exp req=1 addr=0", mem_req_o, mem_addr_o);
        end
    endtask

    task automatic test_basic();
        logic [31:0] ea;
        do_reset();
        mem_gnt_i = 1'b1; inst_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ea = 32'(k) << 2;
            tick();
            mem_rvalid_i = 1'b0;
            checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== ea) begin
                errors++; $display("FAIL basic_req k=%0d got req=%0b addr=%h exp req=1 addr=%h", k, mem_req_o, mem_addr_o, ea);
            end
            checks++; if (inst_valid_o !== (k > 0)) begin
                errors++; $display("FAIL basic_valid_odd k=%0d got=%0b exp=%0b", k, inst_valid_o, (k > 0));
            end
            if (k > 0) begin
                checks++; if (inst_pc_o !== ea - 32'd4 || inst_o !== mem_word(ea - 32'd4)) begin
                    errors++; $display("FAIL basic_inst k=%0d got pc=%h inst=%h exp pc=%h inst=%h", k, inst_pc_o, inst_o, ea - 32'd4, mem_word(ea - 32'd4));
                end
            end
            tick();
            checks++; if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin
                errors++; $display("FAIL basic_even k=%0d got req=%0b valid=%0b exp 0 0", k, mem_req_o, inst_valid_o);
            end
            mem_rvalid_i = 1'b1; mem_rdata_i = mem_word(ea);
        end
        tick();
        mem_rvalid_i = 1'b0;
        checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h8 || inst_o !== mem_word(32'h8)) begin
            errors++; $display("FAIL basic_last got valid=%0b pc=%h inst=%h exp 1 8 %h", inst_valid_o, inst_pc_o, inst_o, mem_word(32'h8));
        end
    endtask

    task automatic test_full_stall();
        logic [31:0] oaddr;
        bit          outstanding;
        int          grants;
        int          late_reqs;
        do_reset();
        mem_gnt_i = 1'b1; inst_ready_i = 1'b0;
        outstanding = 1'b0; grants = 0; late_reqs = 0; oaddr = 32'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (outstanding) begin mem_rvalid_i = 1'b1; mem_rdata_i = mem_word(oaddr); outstanding = 1'b0; end
            else begin mem_rvalid_i = 1'b0; end
            if (mem_req_o) begin grants++; oaddr = mem_addr_o; outstanding = 1'b1; if (i >= 4) late_reqs++; end
        end
        checks++; if (grants !== 2 || late_reqs !== 0) begin
            errors++; $display("FAIL full_grants got grants=%0d late=%0d exp 2 0", grants, late_reqs);
        end
        checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h0 || inst_o !== mem_word(32'h0)) begin
            errors++; $display("FAIL full_head got valid=%0b pc=%h exp 1 0", inst_valid_o, inst_pc_o);
        end
        inst_ready_i = 1'b1; grants = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) inst_ready_i = 1'b0;
            if (outstanding) begin mem_rvalid_i = 1'b1; mem_rdata_i = mem_word(oaddr); outstanding = 1'b0; end
            else begin mem_rvalid_i = 1'b0; end
            if (mem_req_o) begin grants++; oaddr = mem_addr_o; outstanding = 1'b1; end
        end
        checks++; if (grants !== 1 || oaddr !== 32'h8) begin
            errors++; $display("FAIL refill_one got grants=%0d addr=%h exp 1 8", grants, oaddr);
        end
        checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h4) begin
            errors++; $display("FAIL refill_head got valid=%0b pc=%h exp 1 4", inst_valid_o, inst_pc_o);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        mem_gnt_i = 1'b1; inst_ready_i = 1'b1;
        tick();
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
            errors++; $display("FAIL rw_first got req=%0b addr=%h exp 1 0", mem_req_o, mem_addr_o);
        end
        tick();
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h103;
        for (int i = 0; i < 2; i++) begin
            tick();
            redirect_valid_i = 1'b0;
            checks++; if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin
                errors++; $display("FAIL rw_drop i=%0d got req=%0b valid=%0b exp 0 0", i, mem_req_o, inst_valid_o);
            end
        end
        mem_rvalid_i = 1'b1; mem_rdata_i = mem_word(32'h0);
        tick();
        mem_rvalid_i = 1'b0;
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || inst_valid_o !== 1'b0) begin
            errors++; $display("FAIL rw_target got req=%0b addr=%h valid=%0b exp 1 100 0", mem_req_o, mem_addr_o, inst_valid_o);
        end
        tick();
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rw_stale got=%0b exp=0", inst_valid_o); end
        mem_rvalid_i = 1'b1; mem_rdata_i = mem_word(32'h100);
        tick();
        mem_rvalid_i = 1'b0;
        checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h100 || inst_o !== mem_word(32'h100)) begin
            errors++; $display("FAIL rw_inst got valid=%0b pc=%h inst=%h exp 1 100 %h", inst_valid_o, inst_pc_o, inst_o, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_req();
        do_reset();
        mem_gnt_i = 1'b0; inst_ready_i = 1'b1;
        tick();
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h200;
        for (int i = 0; i < 3; i++) begin
            tick();
            redirect_valid_i = 1'b0;
            checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0 || inst_valid_o !== 1'b0) begin
                errors++; $display("FAIL rr_hold i=%0d got req=%0b addr=%h exp 1 0", i, mem_req_o, mem_addr_o);
            end
        end
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rr_dropwait got req=%0b exp 0", mem_req_o); end
        mem_rvalid_i = 1'b1; mem_rdata_i = mem_word(32'h0);
        tick();
        mem_rvalid_i = 1'b0;
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200 || inst_valid_o !== 1'b0) begin
            errors++; $display("FAIL rr_target got req=%0b addr=%h valid=%0b exp 1 200 0", mem_req_o, mem_addr_o, inst_valid_o);
        end
        mem_gnt_i = 1'b1;
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = mem_word(32'h200);
        tick();
        mem_rvalid_i = 1'b0;
        checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h200 || inst_o !== mem_word(32'h200)) begin
            errors++; $display("FAIL rr_inst got valid=%0b pc=%h exp 1 200", inst_valid_o, inst_pc_o);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        mem_gnt_i = 1'b1; inst_ready_i = 1'b1;
        redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
        tick();
        redirect_valid_i = 1'b0;
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_req got req=%0b addr=%h exp 1 fffffffc", mem_req_o, mem_addr_o);
        end
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = mem_word(32'hFFFF_FFFC);
        tick();
        mem_rvalid_i = 1'b0;
        checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_inst got valid=%0b pc=%h exp 1 fffffffc", inst_valid_o, inst_pc_o);
        end
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
            errors++; $display("FAIL wrap_next got req=%0b addr=%h exp 1 0", mem_req_o, mem_addr_o);
        end
    endtask

    task automatic test_reset_wait();
        do_reset();
        mem_gnt_i = 1'b1; inst_ready_i = 1'b0;
        tick();
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = mem_word(32'h0);
        tick();
        mem_rvalid_i = 1'b0;
        checks++; if (inst_valid_o !== 1'b1 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h4) begin
            errors++; $display("FAIL rstw_setup got valid=%0b req=%0b addr=%h exp 1 1 4", inst_valid_o, mem_req_o, mem_addr_o);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++; if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b0 || mem_addr_o !== 32'h0) begin
            errors++; $display("FAIL rstw_reset got valid=%0b req=%0b addr=%h exp 0 0 0", inst_valid_o, mem_req_o, mem_addr_o);
        end
        rst = 1'b0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = mem_word(32'h4);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0 || inst_valid_o !== 1'b0) begin
                errors++; $display("FAIL rstw_late i=%0d got req=%0b addr=%h valid=%0b exp 1 0 0", i, mem_req_o, mem_addr_o, inst_valid_o);
            end
        end
        mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = mem_word(32'h0);
        tick();
        mem_rvalid_i = 1'b0;
        checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h0 || inst_o !== mem_word(32'h0)) begin
            errors++; $display("FAIL rstw_refetch got valid=%0b pc=%h inst=%h exp 1 0 %h", inst_valid_o, inst_pc_o, inst_o, mem_word(32'h0));
        end
    endtask

    // Random traffic: memory with random grant/latency and spurious rvalid,
    // random decode backpressure and redirects; the delivered stream must be
    // consecutive words starting from the last redirect target.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] oaddr;
        bit          outstanding;
        int          delay;
        int          delivered;
        do_reset();
        exp_pc = 32'h0; oaddr = 32'h0; outstanding = 1'b0; delay = 0; delivered = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
            if (outstanding) begin
                checks++; if (mem_req_o !== 1'b0) begin
                    errors++; $display("FAIL rnd_one_outstanding cyc=%0d got req=%0b exp 0", cyc, mem_req_o);
                end
                if (delay == 0) begin
                    mem_rvalid_i = 1'b1; mem_rdata_i = mem_word(oaddr); outstanding = 1'b0;
                end else begin
                    delay--;
                end
            end else if ($urandom_range(9) == 0) begin
                mem_rvalid_i = 1'b1; mem_rdata_i = $urandom;
            end
            mem_gnt_i = ($urandom_range(9) < 7);
            if (mem_req_o && mem_gnt_i) begin
                checks++; if (mem_addr_o[1:0] !== 2'b00) begin
                    errors++; $display("FAIL rnd_align cyc=%0d got addr=%h", cyc, mem_addr_o);
                end
                outstanding = 1'b1; oaddr = mem_addr_o; delay = $urandom_range(2);
            end
            inst_ready_i = ($urandom_range(9) < 7);
            if (inst_valid_o && inst_ready_i) begin
                checks++; if (inst_pc_o !== exp_pc || inst_o !== mem_word(exp_pc)) begin
                    errors++; $display("FAIL rnd_stream cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h", cyc, inst_pc_o, inst_o, exp_pc, mem_word(exp_pc));
                    exp_pc = inst_pc_o;
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            redirect_valid_i = ($urandom_range(49) == 0);
            if (redirect_valid_i) begin
                redirect_pc_i = $urandom;
                if ($urandom_range(3) == 0) redirect_pc_i = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                exp_pc = redirect_pc_i & 32'hFFFF_FFFC;
            end
        end
        tick();
        idle_inputs();
        checks++; if (delivered < 200) begin
            errors++; $display("FAIL rnd_progress got delivered=%0d exp at least 200", delivered);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_full_stall();
        test_redirect_wait();
        test_redirect_req();
        test_wrap();
        test_reset_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset; bits[1:0] are zero.
REQ-002 Parameter FIFO_DEPTH, default 2, SHALL be the instruction buffer depth, fixed at 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 redirect_valid_i  input  1  SHALL be a branch/jump redirect strobe, one cycle.
REQ-006 redirect_pc_i  input  32  SHALL be the redirect target, sampled when redirect_valid_i=1.
REQ-007 mem_req_o  output  1  SHALL be the instruction-memory request valid.
REQ-008 mem_addr_o  output  32  SHALL be the fetch address, word aligned.
REQ-009 mem_gnt_i  input  1  SHALL indicate the memory accepted the request this cycle.
REQ-010 mem_rvalid_i  input  1  SHALL indicate mem_rdata_i is valid.
REQ-011 mem_rdata_i  input  32  SHALL be the returned instruction word.
REQ-012 inst_valid_o  output  1  SHALL indicate inst_o/inst_pc_o are valid to decode.
REQ-013 inst_ready_i  input  1  SHALL indicate decode accepts the instruction this cycle.
REQ-014 inst_o  output  32  SHALL be the buffered instruction word.
REQ-015 inst_pc_o  output  32  SHALL be the address that instruction_was fetched from.

Function
REQ-016 States SHALL be IDLE, REQ, WAIT, DROP_REQ, DROP_WAIT; at most one memory request outstanding.
REQ-017 IDLE->REQ SHALL occur when the FIFO count plus outstanding requests is below 2; otherwise IDLE holds.
REQ-018 In REQ/DROP_REQ, mem_req_o=1 and mem_addr_o SHALL stay stable until mem_gnt_i=1.
REQ-019 REQ with gnt SHALL go to WAIT; WAIT with rvalid SHALL push {rdata, addr} into the FIFO, advance pc by 4, and go to REQ if space remains, else IDLE.
REQ-020 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-021 mem_rvalid_i SHALL be ignored outside WAIT/DROP_WAIT.
REQ-022 Redirect SHALL flush the FIFO and load pc with {redirect_pc_i[31:2],2'b00} in the same cycle.
REQ-023 Redirect in IDLE, or in WAIT with rvalid in the same cycle, SHALL discard any returning data and go to REQ at the new pc next cycle.
REQ-024 Redirect in WAIT without rvalid SHALL go to DROP_WAIT; a response there SHALL be discarded, then the block goes to REQ.
REQ-025 Redirect in REQ without gnt SHALL go to DROP_REQ with the old address held; with gnt SHALL go to DROP_WAIT.
REQ-026 DROP_REQ with gnt SHALL go to DROP_WAIT.
REQ-027 A redirect in any DROP state SHALL only update pc; the drop continues.
REQ-028 inst_valid_o SHALL equal FIFO non-empty; inst_o/inst_pc_o SHALL come from the FIFO head, registered.
REQ-029 A pushed response SHALL appear on inst_valid_o one cycle after mem_rvalid_i.
REQ-030 Pop SHALL occur on inst_valid_o & inst_ready_i; a push and a pop in one cycle SHALL both take effect, count unchanged.
REQ-031 Redirect with a handshake in the same cycle: the handshake SHALL count as consumed; redirect flush wins for the remaining entries.
REQ-032 With mem_gnt_i tied 1 and one-cycle rvalid, steady-state throughput SHALL be one instruction per two cycles.

Reset
REQ-033 While rst=1: state=IDLE, pc=RESET_PC, FIFO empty, mem_req_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, mem_addr_o=RESET_PC.
REQ-034 Reset mid-request SHALL abandon the request; responses arriving after reset SHALL be ignored until the first new grant.
REQ-035 First mem_req_o=1 SHALL occur in the first cycle after rst deasserts (IDLE->REQ on that edge).

Structure
REQ-036 Package fetch_pkg SHALL hold the state enum, the RESET_PC default and the width constants.
REQ-037 The FIFO SHALL be a sub-module fetch_fifo (2-entry, 64-bit data, push/pop/flush, count out).

Verification
REQ-038 Reset release, gnt=1, rvalid next cycle, ready=1 -> addresses 0x0,0x4,0x8 fetched; inst_pc_o matches; inst_valid_o one cycle after each rvalid.
REQ-039 ready=0 -> after two responses, FIFO full, mem_req_o stays 0; ready=1 for one cycle -> exactly one new request issued.
REQ-040 Redirect to 0x103 while in WAIT, rvalid two cycles later -> that data dropped; next mem_addr_o=0x100; no stale inst_valid_o.
REQ-041 Redirect while in REQ with gnt=0 for 3 cycles -> mem_addr_o held at old value; its response dropped; then request to target.
REQ-042 pc=0xFFFF_FFFC fetched -> next mem_addr_o=0x0000_0000.
REQ-043 Assert rst while in WAIT with FIFO holding 1 entry -> next cycle inst_valid_o=0, mem_req_o=0; late rvalid ignored.
